// File: rtl/pcm_pkg.sv
// Shared sample-width constants and playback FSM state type for the PCM FIFO player.
// Pure declarations; no timing or flow-control behaviour of its own.
package pcm_pkg;

    localparam int                  SAMPLE_W     = 8;
    localparam logic [SAMPLE_W-1:0] PCM_MIDSCALE = 8'h80;
    localparam logic [SAMPLE_W-1:0] UNDERRUN_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2
    } pcm_state_e;

    // Increment that sticks at UNDERRUN_MAX instead of wrapping.
    function automatic logic [SAMPLE_W-1:0] sat_inc(input logic [SAMPLE_W-1:0] v);
        return (v == UNDERRUN_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pcm_pwm_dac.sv
// 8-bit PWM DAC: duty latched from sample at each 256-cycle period boundary, output registered.
// One cycle from counter compare to pwm_out; no backpressure, sample may change at any time.
module pcm_pwm_dac
    import pcm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample,
    output logic                pwm_out
);

    logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SAMPLE_W-1:0] duty_q,    duty_d;
    logic                pwm_out_q, pwm_out_d;

    // Duty only moves when the counter wraps, so a period never mixes two duty values.
    always_comb begin
        pwm_cnt_d = en ? pwm_cnt_q + 1'b1 : '0;
        duty_d    = (pwm_cnt_q == '1) ? sample : duty_q;
        pwm_out_d = en && (pwm_cnt_q < duty_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= '0;
            duty_q    <= PCM_MIDSCALE;
            pwm_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;

endmodule

// File: rtl/pcm_fifo_player.sv
// Sample-rate FIFO consumer: pops one byte per tick, holds it as the PCM sample, counts underruns.
// Tick->fifo_rd 1 cycle, tick->sample/sample_stb 3 cycles; an empty FIFO at a tick is counted, not waited on.
module pcm_fifo_player
    import pcm_pkg::*;
#(
    parameter int CLK_DIV = 2268,
    parameter int DIV_W   = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic [SAMPLE_W-1:0] fifo_dout,
    output logic                fifo_rd,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_stb,
    output logic                pwm_out,
    output logic [SAMPLE_W-1:0] underrun_cnt
);

    if (CLK_DIV < 4 || (CLK_DIV >> DIV_W) != 0) begin : g_param_check
        $error("pcm_fifo_player: CLK_DIV must be >= 4 and representable in DIV_W bits");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                tick;

    pcm_state_e          state_q;
    logic                fifo_rd_q;
    logic                sample_stb_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] underrun_q;

    // Divider parks at zero while disabled so re-enable always yields a full first interval.
    always_comb begin
        tick = en && (div_cnt_q == DIV_LAST);
        if (!en || tick) begin
            div_cnt_d = '0;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // REQ and CAPTURE ignore en: once a byte is popped it is always delivered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fifo_rd_q    <= 1'b0;
            sample_stb_q <= 1'b0;
            sample_q     <= PCM_MIDSCALE;
            underrun_q   <= '0;
        end else begin
            fifo_rd_q    <= 1'b0;
            sample_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (fifo_empty) begin
                            underrun_q <= sat_inc(underrun_q);
                        end else begin
                            state_q   <= REQ;
                            fifo_rd_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    sample_q     <= fifo_dout;
                    sample_stb_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    pcm_pwm_dac u_pwm_dac (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .sample  (sample_q),
        .pwm_out (pwm_out)
    );

    assign fifo_rd      = fifo_rd_q;
    assign sample       = sample_q;
    assign sample_stb   = sample_stb_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_pcm_fifo_player.sv
// Scoreboard bench for pcm_fifo_player: FIFO model feeds the DUT, a negedge monitor checks every cycle
// against tick times derived from how long en has been continuously high.
module tb_pcm_fifo_player;

    localparam int CD = 8;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       en         = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout  = 8'h00;
    logic       fifo_rd;
    logic [7:0] sample;
    logic       sample_stb;
    logic       pwm_out;
    logic [7:0] underrun_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    pcm_fifo_player #(.CLK_DIV(CD), .DIV_W(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_dout    (fifo_dout),
        .fifo_rd      (fifo_rd),
        .sample       (sample),
        .sample_stb   (sample_stb),
        .pwm_out      (pwm_out),
        .underrun_cnt (underrun_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: bytes waiting to be popped by the DUT.
    logic [7:0] fifo_q[$];

    task automatic fifo_push(input logic [7:0] b);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // Reference model state.
    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_tmp;
    int         run_len   = 0;
    int         exp_unr   = 0;
    logic [7:0] last_samp = 8'h80;
    logic       e_en, e_rst, e_emp, tk;

    // Inputs as seen by the DUT at this edge.
    always @(posedge clk) begin
        cyc++;
        e_en  = en;
        e_rst = reset;
        e_emp = fifo_empty;
    end

    always @(negedge clk) begin
        if (!reset) begin
            run_len   = 0;
            exp_unr   = 0;
            last_samp = 8'h80;
            exp_q.delete();
            chk("rst_fifo_rd", fifo_rd, 0);
            chk("rst_sample_stb", sample_stb, 0);
            chk("rst_sample", sample, 8'h80);
            chk("rst_pwm_out", pwm_out, 0);
            chk("rst_underrun", underrun_cnt, 0);
        end else begin
            // A tick ends every CD-th consecutive enabled cycle.
            if (e_rst && e_en) run_len++;
            else run_len = 0;
            tk = (run_len != 0) && (run_len % CD == 0);
            if (tk && e_emp && exp_unr < 255) exp_unr++;

            chk("fifo_rd", fifo_rd, int'(tk && !e_emp));
            chk("underrun_cnt", underrun_cnt, exp_unr);
            if (e_rst && !e_en) chk("pwm_off_when_disabled", pwm_out, 0);

            if (sample_stb) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample_stb", 1, 0);
                end else begin
                    e_tmp = exp_q.pop_front();
                    chk("sample_stb_cycle", cyc, e_tmp.cyc);
                    chk("sample_value", sample, e_tmp.val);
                    last_samp = e_tmp.val;
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    chk("missing_sample_stb", 0, 1);
                    void'(exp_q.pop_front());
                end
                chk("sample_hold", sample, last_samp);
            end

            // Pop on the read strobe; the byte is presented through the following capture cycle.
            if (fifo_rd) begin
                if (fifo_q.size() == 0) begin
                    chk("fifo_rd_on_empty", 1, 0);
                end else begin
                    fifo_dout  = fifo_q.pop_front();
                    e_tmp.cyc  = cyc + 2;
                    e_tmp.val  = fifo_dout;
                    exp_q.push_back(e_tmp);
                    fifo_empty = (fifo_q.size() == 0);
                end
            end
        end
    end

    // Edges until fifo_rd is seen (sampled 1 time unit after each edge), bounded.
    task automatic wait_rd(input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!fifo_rd && n < limit);
        if (!fifo_rd) n = -1;
    endtask

    task automatic count_high(input int cycles, output int h);
        h = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pwm_out) h++;
        end
    endtask

    task automatic wait_rise(input int limit, output int at);
        logic prev;
        int   k;
        prev = pwm_out;
        at   = -1;
        k    = 0;
        while (k < limit && at < 0) begin
            @(negedge clk);
            k++;
            if (pwm_out && !prev) at = cyc;
            prev = pwm_out;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h, r1, r2, k;

        // Reset held, then idle with en low.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_sample", sample, 8'h80);
        chk("idle_underrun", underrun_cnt, 0);
        chk("idle_pwm_out", pwm_out, 0);

        // Streaming from a preloaded FIFO: rd lands in the (CD+1)th cycle counting the one en rose in.
        fifo_push(8'h01);
        fifo_push(8'h03);
        fifo_push(8'h0A);
        en = 1'b1;
        wait_rd(40, n);
        chk("stream_first_rd_delay", n, CD);
        wait_rd(40, n);
        chk("stream_rd_interval_1", n, CD);
        wait_rd(40, n);
        chk("stream_rd_interval_2", n, CD);
        repeat (3) @(posedge clk);
        #1;
        chk("stream_last_sample", sample, 8'h0A);

        // Underrun: FIFO now empty, counter must saturate.
        repeat (300 * CD + 20) @(posedge clk);
        #1;
        chk("underrun_saturated", underrun_cnt, 255);
        chk("underrun_sample_held", sample, 8'h0A);

        // PWM duty windows: any 256-cycle window of a steady duty holds exactly duty highs.
        fifo_push(8'h40);
        repeat (700) @(posedge clk);
        count_high(256, h);
        chk("pwm_duty_40", h, 64);
        @(posedge clk); #1;
        fifo_push(8'h00);
        repeat (700) @(posedge clk);
        count_high(256, h);
        chk("pwm_duty_00", h, 0);
        @(posedge clk); #1;
        fifo_push(8'hFF);
        repeat (700) @(posedge clk);
        count_high(256, h);
        chk("pwm_duty_ff", h, 255);

        // A sample change in the low part of a period must not start the high phase early.
        @(posedge clk); #1;
        fifo_push(8'h40);
        repeat (700) @(posedge clk);
        wait_rise(600, r1);
        chk("pwm_rise_found", int'(r1 >= 0), 1);
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        fifo_push(8'hC0);
        wait_rise(600, r2);
        chk("pwm_mid_period_gap", r2 - r1, 256);
        k = 1;
        while (k < 300) begin
            @(negedge clk);
            if (!pwm_out) break;
            k++;
        end
        chk("pwm_new_duty_run", k, 192);

        // en dropped in the REQ cycle: fetch completes, nothing further until re-enable.
        @(posedge clk); #1;
        fifo_push(8'h5A);
        wait_rd(40, n);
        chk("drop_rd_seen", int'(n > 0), 1);
        en = 1'b0;
        fifo_push(8'h77);
        repeat (30) @(posedge clk);
        #1;
        chk("drop_sample", sample, 8'h5A);
        en = 1'b1;
        wait_rd(40, n);
        chk("reenable_first_rd_delay", n, CD);

        // Async reset in the capture cycle discards the popped byte.
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("async_rst_sample", sample, 8'h80);
        chk("async_rst_stb", sample_stb, 0);
        chk("async_rst_fifo_rd", fifo_rd, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        fifo_push(8'h33);
        wait_rd(40, n);
        chk("post_reset_first_rd_delay", n, CD);
        repeat (5) @(posedge clk);
        #1;
        chk("post_reset_sample", sample, 8'h33);

        // Randomised pushes and enable toggling against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) fifo_push(8'($urandom));
            en = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
        end

        en = 1'b1;
        repeat (20 * CD) @(posedge clk);
        #1 en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("fifo_drained", fifo_q.size(), 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
